// File: rtl/mem_line_pkg.sv
// Shared types and helpers for the line-granular memory responder.
// Holds the FSM state enum, the line-size derivation and the word-slice offset helper.
package mem_line_pkg;

  localparam int unsigned WORD_W = 32;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WAIT = 3'd1,
    XFER = 3'd2,
    DONE = 3'd3,
    REST = 3'd4
  } state_e;

  // Words per line from log2 words per line.
  function automatic int unsigned line_size(input int unsigned line_addr_len);
    return 32'(1) << line_addr_len;
  endfunction

  // Bit offset of word idx inside a packed line.
  function automatic int unsigned word_lsb(input int unsigned idx);
    return WORD_W * idx;
  endfunction

endpackage

// File: rtl/mem_word_ram.sv
// Single-port synchronous 32-bit word RAM, write-first, one-cycle read latency.
// Ports: clk; we (write enable); addr (word address); wdata (write word);
//        rdata (registered read word, shows wdata on a write cycle).
// Contents are not reset; the backing block RAM comes up zero-filled.
module mem_word_ram
  import mem_line_pkg::*;
#(
  parameter int unsigned ADDR_W = 12
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  localparam int unsigned DEPTH = 32'(1) << ADDR_W;

  logic [WORD_W-1:0] mem [DEPTH];

  // Write-first port: a write also forwards its data to the read register.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
      rdata     <= wdata;
    end else begin
      rdata     <= mem[addr];
    end
  end

endmodule

// File: rtl/mem_line_server.sv
// Line-granular main-memory responder behind the data cache refill/writeback path.
// Accepts one line request, waits LATENCY cycles, moves the line word by word
// between the word RAM and a line buffer, then pulses gnt.
// Ports: clk, rst_n (async, active-low); rd_req/wr_req (held until gnt);
//        addr (line address); wr_line (write line); rd_line (read line);
//        gnt (one-cycle completion); busy (not IDLE); rd_count/wr_count (completed ops).
module mem_line_server
  import mem_line_pkg::*;
#(
  parameter int unsigned LINE_ADDR_LEN = 3,
  parameter int unsigned MEM_ADDR_LEN  = 12,
  parameter int unsigned LATENCY       = 8
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    rd_req,
  input  logic                                    wr_req,
  input  logic [MEM_ADDR_LEN-LINE_ADDR_LEN-1:0]   addr,
  input  logic [(WORD_W << LINE_ADDR_LEN)-1:0]    wr_line,
  output logic [(WORD_W << LINE_ADDR_LEN)-1:0]    rd_line,
  output logic                                    gnt,
  output logic                                    busy,
  output logic [31:0]                             rd_count,
  output logic [31:0]                             wr_count
);

  localparam int unsigned LINE_SIZE = line_size(LINE_ADDR_LEN);
  localparam int unsigned LINE_W    = MEM_ADDR_LEN - LINE_ADDR_LEN;
  localparam int unsigned DATA_W    = WORD_W * LINE_SIZE;
  localparam int unsigned CNT_W     = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  state_e                   state;
  logic [CNT_W-1:0]         wait_cnt;
  logic [LINE_ADDR_LEN-1:0] idx;
  logic [LINE_W-1:0]        line_q;
  logic [DATA_W-1:0]        data_q;
  logic                     op_wr_q;

  logic                     ram_we_c;
  logic [MEM_ADDR_LEN-1:0]  ram_addr_c;
  logic [WORD_W-1:0]        ram_wdata_c;
  logic [WORD_W-1:0]        ram_rdata;

  mem_word_ram #(
    .ADDR_W (MEM_ADDR_LEN)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we_c),
    .addr  (ram_addr_c),
    .wdata (ram_wdata_c),
    .rdata (ram_rdata)
  );

  // RAM port drive. Reads run one word ahead because the RAM output is registered:
  // word 0 is addressed in the last WAIT cycle, word i+1 while word i is captured.
  // The index wraps inside its own field, so the line bits never change.
  always_comb begin
    ram_we_c    = 1'b0;
    ram_addr_c  = {line_q, LINE_ADDR_LEN'(0)};
    ram_wdata_c = '0;
    if (state == XFER) begin
      if (op_wr_q) begin
        ram_we_c    = 1'b1;
        ram_addr_c  = {line_q, idx};
        ram_wdata_c = data_q[word_lsb(32'(idx)) +: WORD_W];
      end else begin
        ram_addr_c  = {line_q, idx + LINE_ADDR_LEN'(1)};
      end
    end
  end

  // Request FSM, line buffer and access counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      wait_cnt <= '0;
      idx      <= '0;
      line_q   <= '0;
      data_q   <= '0;
      op_wr_q  <= 1'b0;
      rd_line  <= '0;
      gnt      <= 1'b0;
      busy     <= 1'b0;
      rd_count <= '0;
      wr_count <= '0;
    end else begin
      gnt <= 1'b0;
      case (state)
        IDLE: begin
          // Write wins a tie so a writeback lands before its refill.
          if (wr_req || rd_req) begin
            op_wr_q  <= wr_req;
            line_q   <= addr;
            data_q   <= wr_line;
            wait_cnt <= CNT_W'(LATENCY - 1);
            busy     <= 1'b1;
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (wait_cnt == '0) begin
            idx   <= '0;
            state <= XFER;
          end else begin
            wait_cnt <= wait_cnt - CNT_W'(1);
          end
        end
        XFER: begin
          if (!op_wr_q) begin
            rd_line[word_lsb(32'(idx)) +: WORD_W] <= ram_rdata;
          end
          idx <= idx + LINE_ADDR_LEN'(1);
          if (idx == LINE_ADDR_LEN'(LINE_SIZE - 1)) begin
            // gnt and the counter bump become visible in the DONE cycle.
            gnt   <= 1'b1;
            state <= DONE;
            if (op_wr_q) begin
              wr_count <= wr_count + 32'd1;
            end else begin
              rd_count <= rd_count + 32'd1;
            end
          end
        end
        DONE: begin
          state <= REST;
        end
        REST: begin
          // Gives the requester a cycle to drop its held request.
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
